mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS-subset CPU (addu, subu, ori, lw, sw, beq, lui, j). It is the producer side of the ALU interface: it sequences each instruction through fetch/decode/execute/memory/write-back states. In every cycle it drives `ALUOp` and the datapath mux selects and write enables. It consumes only the IR opcode/funct fields and the datapath zero flag.

---
 rtl/mc_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU (addu, subu, ori, lw, sw, beq, lui, j).
// Registered state only; every output is decoded combinationally from state, IR fields, Zero and reset.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic [1:0] NPCSel,
  output logic       IRWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       MemWr,
  output logic       ALUSrc,
  output logic [1:0] ExtOp,
  output logic [3:0] ALUOp,
  output logic       InstrDone,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXE    = 4'd2,
    MEM_RD = 4'd3,
    MEM_WR = 4'd4,
    WB_ALU = 4'd5,
    WB_MEM = 4'd6,
    BRANCH = 4'd7,
    JUMP   = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;

  state_t state_reg;

  logic is_rtype;
  logic is_addu;
  logic is_subu;
  logic is_ori;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_lui;
  logic is_j;
  logic is_alu_wb;
  logic is_legal;

  logic [3:0] ins_aluop;
  logic       ins_alusrc;
  logic [1:0] ins_extop;

  // Instruction classification from the IR fields.
  always_comb begin
    is_rtype  = (op == OP_RTYPE);
    is_addu   = is_rtype && (funct == FN_ADDU);
    is_subu   = is_rtype && (funct == FN_SUBU);
    is_ori    = (op == OP_ORI);
    is_lw     = (op == OP_LW);
    is_sw     = (op == OP_SW);
    is_beq    = (op == OP_BEQ);
    is_lui    = (op == OP_LUI);
    is_j      = (op == OP_J);
    is_alu_wb = is_addu || is_subu || is_ori || is_lui;
    is_legal  = is_alu_wb || is_lw || is_sw || is_beq || is_j;
  end

  // Per-instruction ALU selects, held from EXE through the final state.
  always_comb begin
    ins_aluop  = ALU_ADD;
    ins_alusrc = 1'b0;
    ins_extop  = EXT_ZERO;
    if (is_subu) begin
      ins_aluop = ALU_SUB;
    end else if (is_ori) begin
      ins_aluop  = ALU_OR;
      ins_alusrc = 1'b1;
      ins_extop  = EXT_ZERO;
    end else if (is_lui) begin
      ins_alusrc = 1'b1;
      ins_extop  = EXT_HI;
    end else if (is_lw || is_sw) begin
      ins_alusrc = 1'b1;
      ins_extop  = EXT_SIGN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      case (state_reg)
        FETCH:  state_reg <= DECODE;
        DECODE: begin
          if (is_alu_wb || is_lw || is_sw) state_reg <= EXE;
          else if (is_beq)                 state_reg <= BRANCH;
          else if (is_j)                   state_reg <= JUMP;
          else                             state_reg <= FETCH;
        end
        EXE: begin
          if (is_lw)      state_reg <= MEM_RD;
          else if (is_sw) state_reg <= MEM_WR;
          else            state_reg <= WB_ALU;
        end
        MEM_RD:  state_reg <= WB_MEM;
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign state = state_reg;

  always_comb begin
    PCWr      = 1'b0;
    NPCSel    = NPC_SEQ;
    IRWr      = 1'b0;
    RegWr     = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    MemWr     = 1'b0;
    ALUSrc    = 1'b0;
    ExtOp     = EXT_ZERO;
    ALUOp     = ALU_ADD;
    InstrDone = 1'b0;
    case (state_reg)
      FETCH: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      DECODE: begin
        InstrDone = !is_legal;
      end
      EXE, MEM_RD: begin
        ALUOp  = ins_aluop;
        ALUSrc = ins_alusrc;
        ExtOp  = ins_extop;
      end
      MEM_WR: begin
        ALUOp     = ins_aluop;
        ALUSrc    = ins_alusrc;
        ExtOp     = ins_extop;
        MemWr     = 1'b1;
        InstrDone = 1'b1;
      end
      WB_ALU: begin
        ALUOp     = ins_aluop;
        ALUSrc    = ins_alusrc;
        ExtOp     = ins_extop;
        RegWr     = 1'b1;
        RegDst    = is_rtype;
        InstrDone = 1'b1;
      end
      WB_MEM: begin
        ALUOp     = ins_aluop;
        ALUSrc    = ins_alusrc;
        ExtOp     = ins_extop;
        RegWr     = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUOp     = ALU_SUB;
        ExtOp     = EXT_SIGN;
        NPCSel    = NPC_BR;
        PCWr      = Zero;
        InstrDone = 1'b1;
      end
      JUMP: begin
        PCWr      = 1'b1;
        NPCSel    = NPC_J;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
    // Reset squashes every architectural write, including a coinciding final state.
    if (reset) begin
      PCWr      = 1'b0;
      IRWr      = 1'b0;
      RegWr     = 1'b0;
      MemWr     = 1'b0;
      InstrDone = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: one record per clock cycle, plus cycles-per-instruction sequences.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       Zero;
  logic       PCWr;
  logic [1:0] NPCSel;
  logic       IRWr;
  logic       RegWr;
  logic       RegDst;
  logic       MemtoReg;
  logic       MemWr;
  logic       ALUSrc;
  logic [1:0] ExtOp;
  logic [3:0] ALUOp;
  logic       InstrDone;
  logic [3:0] state;

  int checks;
  int fails;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .Zero(Zero),
    .PCWr(PCWr), .NPCSel(NPCSel), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .MemWr(MemWr), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
    .ALUOp(ALUOp), .InstrDone(InstrDone), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] st;
    logic [15:0] outs;
  } vec_t;

  vec_t vecs[$];

  // Output bundle: PCWr NPCSel IRWr RegWr RegDst MemtoReg MemWr ALUSrc ExtOp ALUOp InstrDone
  localparam logic [15:0] O_FETCH  = 16'b1_00_1_0_0_0_0_0_00_0000_0;
  localparam logic [15:0] O_NONE   = 16'b0_00_0_0_0_0_0_0_00_0000_0;
  localparam logic [15:0] O_ILL    = 16'b0_00_0_0_0_0_0_0_00_0000_1;
  localparam logic [15:0] O_ADDU_W = 16'b0_00_0_1_1_0_0_0_00_0000_1;
  localparam logic [15:0] O_SUBU_E = 16'b0_00_0_0_0_0_0_0_00_0001_0;
  localparam logic [15:0] O_SUBU_W = 16'b0_00_0_1_1_0_0_0_00_0001_1;
  localparam logic [15:0] O_ORI_E  = 16'b0_00_0_0_0_0_0_1_00_0010_0;
  localparam logic [15:0] O_ORI_W  = 16'b0_00_0_1_0_0_0_1_00_0010_1;
  localparam logic [15:0] O_MEM_E  = 16'b0_00_0_0_0_0_0_1_01_0000_0;
  localparam logic [15:0] O_LW_W   = 16'b0_00_0_1_0_1_0_1_01_0000_1;
  localparam logic [15:0] O_SW_M   = 16'b0_00_0_0_0_0_1_1_01_0000_1;
  localparam logic [15:0] O_BEQ_T  = 16'b1_01_0_0_0_0_0_0_01_0001_1;
  localparam logic [15:0] O_BEQ_N  = 16'b0_01_0_0_0_0_0_0_01_0001_1;
  localparam logic [15:0] O_LUI_E  = 16'b0_00_0_0_0_0_0_1_10_0000_0;
  localparam logic [15:0] O_LUI_W  = 16'b0_00_0_1_0_0_0_1_10_0000_1;
  localparam logic [15:0] O_JUMP   = 16'b1_10_0_0_0_0_0_0_00_0000_1;

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [3:0] s, input logic [15:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.st = s; v.outs = e;
    vecs.push_back(v);
  endtask

  task automatic run_cpi(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int exp_cycles, input string name);
    int n;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; op = o; funct = f; Zero = z;
    #1;
    n = 1;
    while (!InstrDone && n < 16) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!InstrDone || n != exp_cycles) begin
      fails++;
      $display("FAIL cpi_%s: got %0d cycles (done=%b), expected %0d", name, n, InstrDone, exp_cycles);
    end else begin
      $display("cpi_%s: %0d cycles", name, n);
    end
  endtask

  logic [15:0] got;

  initial begin
    checks = 0;
    fails  = 0;
    reset = 1'b1; op = 6'd0; funct = 6'd0; Zero = 1'b0;

    add(1, 6'h00, 6'h00, 0, 4'd0, O_NONE);        // second reset cycle
    add(0, 6'h00, 6'h21, 0, 4'd0, O_FETCH);       // addu
    add(0, 6'h00, 6'h21, 0, 4'd1, O_NONE);
    add(0, 6'h00, 6'h21, 0, 4'd2, O_NONE);
    add(0, 6'h00, 6'h21, 0, 4'd5, O_ADDU_W);
    add(0, 6'h00, 6'h23, 0, 4'd0, O_FETCH);       // subu
    add(0, 6'h00, 6'h23, 0, 4'd1, O_NONE);
    add(0, 6'h00, 6'h23, 0, 4'd2, O_SUBU_E);
    add(0, 6'h00, 6'h23, 0, 4'd5, O_SUBU_W);
    add(0, 6'h0d, 6'h00, 0, 4'd0, O_FETCH);       // ori
    add(0, 6'h0d, 6'h00, 0, 4'd1, O_NONE);
    add(0, 6'h0d, 6'h00, 0, 4'd2, O_ORI_E);
    add(0, 6'h0d, 6'h00, 0, 4'd5, O_ORI_W);
    add(0, 6'h23, 6'h00, 0, 4'd0, O_FETCH);       // lw
    add(0, 6'h23, 6'h00, 0, 4'd1, O_NONE);
    add(0, 6'h23, 6'h00, 0, 4'd2, O_MEM_E);
    add(0, 6'h23, 6'h00, 0, 4'd3, O_MEM_E);
    add(0, 6'h23, 6'h00, 0, 4'd6, O_LW_W);
    add(0, 6'h2b, 6'h00, 0, 4'd0, O_FETCH);       // sw
    add(0, 6'h2b, 6'h00, 0, 4'd1, O_NONE);
    add(0, 6'h2b, 6'h00, 0, 4'd2, O_MEM_E);
    add(0, 6'h2b, 6'h00, 0, 4'd4, O_SW_M);
    add(0, 6'h04, 6'h00, 1, 4'd0, O_FETCH);       // beq taken
    add(0, 6'h04, 6'h00, 1, 4'd1, O_NONE);
    add(0, 6'h04, 6'h00, 1, 4'd7, O_BEQ_T);
    add(0, 6'h04, 6'h00, 0, 4'd0, O_FETCH);       // beq not taken
    add(0, 6'h04, 6'h00, 0, 4'd1, O_NONE);
    add(0, 6'h04, 6'h00, 0, 4'd7, O_BEQ_N);
    add(0, 6'h0f, 6'h00, 0, 4'd0, O_FETCH);       // lui
    add(0, 6'h0f, 6'h00, 0, 4'd1, O_NONE);
    add(0, 6'h0f, 6'h00, 0, 4'd2, O_LUI_E);
    add(0, 6'h0f, 6'h00, 0, 4'd5, O_LUI_W);
    add(0, 6'h02, 6'h00, 0, 4'd0, O_FETCH);       // j
    add(0, 6'h02, 6'h00, 0, 4'd1, O_NONE);
    add(0, 6'h02, 6'h00, 0, 4'd8, O_JUMP);
    add(0, 6'h3f, 6'h00, 0, 4'd0, O_FETCH);       // illegal opcode
    add(0, 6'h3f, 6'h00, 0, 4'd1, O_ILL);
    add(0, 6'h00, 6'h20, 0, 4'd0, O_FETCH);       // illegal R-type funct
    add(0, 6'h00, 6'h20, 0, 4'd1, O_ILL);
    add(0, 6'h23, 6'h00, 0, 4'd0, O_FETCH);       // lw abandoned by reset in MEM_RD
    add(0, 6'h23, 6'h00, 0, 4'd1, O_NONE);
    add(0, 6'h23, 6'h00, 0, 4'd2, O_MEM_E);
    add(1, 6'h23, 6'h00, 0, 4'd3, O_MEM_E);
    add(0, 6'h23, 6'h00, 0, 4'd0, O_FETCH);
    add(0, 6'h2b, 6'h00, 0, 4'd1, O_NONE);        // sw with reset on its final state
    add(0, 6'h2b, 6'h00, 0, 4'd2, O_MEM_E);
    add(1, 6'h2b, 6'h00, 0, 4'd4, 16'b0_00_0_0_0_0_0_1_01_0000_0);
    add(0, 6'h2b, 6'h00, 0, 4'd0, O_FETCH);
    add(1, 6'h04, 6'h00, 1, 4'd1, O_NONE);        // reset in DECODE
    add(1, 6'h04, 6'h00, 1, 4'd0, O_NONE);        // reset held in FETCH: enables off
    add(0, 6'h04, 6'h00, 1, 4'd0, O_FETCH);

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct; Zero = vecs[i].zero;
      #1;
      got = {PCWr, NPCSel, IRWr, RegWr, RegDst, MemtoReg, MemWr, ALUSrc, ExtOp, ALUOp, InstrDone};
      $display("vec %0d: rst=%b op=%h state=%0d outs=%h", i, reset, op, state, got);
      checks++;
      if (state !== vecs[i].st) begin
        fails++;
        $display("FAIL state[%0d]: got %0d, expected %0d", i, state, vecs[i].st);
      end
      checks++;
      if (got !== vecs[i].outs) begin
        fails++;
        $display("FAIL outs[%0d]: got %b, expected %b", i, got, vecs[i].outs);
      end
    end

    run_cpi(6'h00, 6'h21, 1'b0, 4, "addu");
    run_cpi(6'h2b, 6'h00, 1'b0, 4, "sw");
    run_cpi(6'h23, 6'h00, 1'b0, 5, "lw");
    run_cpi(6'h04, 6'h00, 1'b0, 3, "beq");
    run_cpi(6'h02, 6'h00, 1'b0, 3, "j");
    run_cpi(6'h3f, 6'h00, 1'b0, 2, "illegal");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
